// File: rtl/front_end_ctrl.sv
// Front-end pipeline sequencer: derives fetch, ID->rename and sRAT flush/stall
// controls from backend back-pressure, ROB redirects, idle commit and interrupts,
// and keeps saturating stall/flush event counters for performance debug.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; stalls follow backend back-pressure
// RECOVER  | sRAT being restored from the aRAT; rename blocked
// IDLE     | idle committed; fetch held, rename fed bubbles until interrupt
module front_end_ctrl #(
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             full_prf,
  input  logic             full_rob,
  input  logic             full_iq,
  input  logic             flush_req,
  input  logic             idle_commit,
  input  logic             has_int,
  input  logic             cnt_clr,
  output logic             flush_if,
  output logic             stall_if,
  output logic             flush_id,
  output logic             stall_id,
  output logic             flush_srat,
  output logic             stall_srat,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  // Window counter reload value; RECOVER lasts this value + 1 cycles.
  localparam logic [3:0] RC_LOAD = 4'(RECOVER_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_rec_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_bp;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_bp = full_prf | full_rob | full_iq;

  // A stall cycle is only counted in RUN when no redirect overrides it.
  assign w_stall_inc = (r_state == ST_RUN) && w_bp && !flush_req && !(&r_stall_cnt);
  assign w_flush_inc = flush_req && !(&r_flush_cnt);

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Control outputs: zero-latency decode of current state and inputs.
  always_comb begin
    flush_if   = 1'b0;
    stall_if   = 1'b0;
    flush_id   = 1'b0;
    stall_id   = 1'b0;
    flush_srat = 1'b0;
    stall_srat = 1'b0;
    if (rst || flush_req) begin
      flush_if   = 1'b1;
      flush_id   = 1'b1;
      flush_srat = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          stall_if   = w_bp;
          stall_id   = w_bp;
          stall_srat = w_bp;
        end
        ST_RECOVER: begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_srat = 1'b1;
        end
        ST_IDLE: begin
          stall_if = 1'b1;
          flush_id = 1'b1;
        end
        default: begin
          stall_if = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state and recovery window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_rec_cnt <= 4'd0;
    end else if (flush_req) begin
      r_state   <= ST_RECOVER;
      r_rec_cnt <= RC_LOAD;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (idle_commit) r_state <= ST_IDLE;
        end
        ST_RECOVER: begin
          if (r_rec_cnt == 4'd0) r_state <= ST_RUN;
          else                   r_rec_cnt <= r_rec_cnt - 4'd1;
        end
        ST_IDLE: begin
          if (has_int) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Saturating event counters; clear wins over any increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_front_end_ctrl.sv
// Self-checking bench for front_end_ctrl (RECOVER_CYCLES=2, CNT_W=4).
module tb_front_end_ctrl;

  localparam int RC = 2;

  localparam logic [7:0] S_RST = 8'h80;
  localparam logic [7:0] S_PRF = 8'h40;
  localparam logic [7:0] S_ROB = 8'h20;
  localparam logic [7:0] S_IQ  = 8'h10;
  localparam logic [7:0] S_FR  = 8'h08;
  localparam logic [7:0] S_IC  = 8'h04;
  localparam logic [7:0] S_HI  = 8'h02;
  localparam logic [7:0] S_CLR = 8'h01;

  logic clk = 1'b0;
  logic rst, full_prf, full_rob, full_iq, flush_req, idle_commit, has_int, cnt_clr;
  logic flush_if, stall_if, flush_id, stall_id, flush_srat, stall_srat;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct packed {
    logic       fif, sif, fid, sid, fsr, ssr;
    logic [1:0] st;
    logic [3:0] scnt, fcnt;
  } obs_t;

  obs_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;

  int m_st, m_rc, m_sc, m_fc;

  front_end_ctrl #(.RECOVER_CYCLES(RC), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .full_prf(full_prf), .full_rob(full_rob), .full_iq(full_iq),
    .flush_req(flush_req), .idle_commit(idle_commit), .has_int(has_int), .cnt_clr(cnt_clr),
    .flush_if(flush_if), .stall_if(stall_if), .flush_id(flush_id), .stall_id(stall_id),
    .flush_srat(flush_srat), .stall_srat(stall_srat), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.fif = flush_if;  o.sif = stall_if;  o.fid = flush_id;
    o.sid = stall_id;  o.fsr = flush_srat; o.ssr = stall_srat;
    o.st = state; o.scnt = stall_cnt; o.fcnt = flush_cnt;
    return o;
  endfunction

  // Expected outputs for the current cycle, from the model's view of the state.
  function automatic obs_t model_out(logic r, logic bp, logic fr);
    obs_t o;
    o = '0;
    o.st   = 2'(m_st);
    o.scnt = 4'(m_sc);
    o.fcnt = 4'(m_fc);
    if (r || fr) begin
      o.fif = 1'b1; o.fid = 1'b1; o.fsr = 1'b1;
    end else if (m_st == 0) begin
      o.sif = bp; o.sid = bp; o.ssr = bp;
    end else if (m_st == 1) begin
      o.sif = 1'b1; o.sid = 1'b1; o.ssr = 1'b1;
    end else begin
      o.sif = 1'b1; o.fid = 1'b1;
    end
    return o;
  endfunction

  task automatic model_edge(logic r, logic bp, logic fr, logic ic, logic hi, logic clr);
    int nst;
    if (r) begin
      m_st = 0; m_rc = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (m_st == 0 && bp && !fr) m_sc = (m_sc >= 15) ? 15 : m_sc + 1;
        if (fr) m_fc = (m_fc >= 15) ? 15 : m_fc + 1;
      end
      nst = m_st;
      if (fr) begin
        nst = 1; m_rc = RC - 1;
      end else if (m_st == 0) begin
        if (ic) nst = 2;
      end else if (m_st == 1) begin
        if (m_rc == 0) nst = 0;
        else m_rc = m_rc - 1;
      end else begin
        if (hi) nst = 0;
      end
      m_st = nst;
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show this cycle.
  task automatic apply(input logic [7:0] s);
    logic bp;
    {rst, full_prf, full_rob, full_iq, flush_req, idle_commit, has_int, cnt_clr} = s;
    bp = s[6] | s[5] | s[4];
    exp_q.push_back(model_out(s[7], bp, s[3]));
    model_edge(s[7], bp, s[3], s[2], s[1], s[0]);
  endtask

  task automatic test_reset();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_RST, S_RST, S_RST, 8'h00, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL reset step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_ROB, S_ROB, S_ROB, S_ROB, 8'h00, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL backpressure step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (stall_cnt !== 4'd4) begin
      errs++; $display("FAIL backpressure stall_cnt: got %0d expected 4", stall_cnt);
    end
    stim = '{S_PRF, 8'h00, S_IQ, S_PRF | S_IQ, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL bp_sources step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush_recover();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_CLR, S_FR, 8'h00, S_ROB, 8'h00, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL flush_recover step %0d: got %h expected %h", i, got, e);
      end
      if (i == 3 && state !== 2'd1) begin
        errs++; $display("FAIL flush_recover window_end: got state %0d expected 1", state);
      end
      if (i == 4 && state !== 2'd0) begin
        errs++; $display("FAIL flush_recover back_to_run: got state %0d expected 0", state);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (flush_cnt !== 4'd1) begin
      errs++; $display("FAIL flush_recover flush_cnt: got %0d expected 1", flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_CLR, S_FR, S_FR, 8'h00, 8'h00, 8'h00,
             S_FR, S_FR, S_FR, 8'h00, 8'h00, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL back_to_back step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (flush_cnt !== 4'd5) begin
      errs++; $display("FAIL back_to_back flush_cnt: got %0d expected 5", flush_cnt);
    end
  endtask

  task automatic test_idle();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_HI, S_IC, 8'h00, S_ROB, S_IC, 8'h00, S_HI, 8'h00,
             S_IC, 8'h00, S_FR | S_HI, 8'h00, 8'h00, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL idle step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ignored();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_FR, S_IC, S_IC | S_ROB, S_HI, S_IQ, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL ignored step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    obs_t got, e;
    for (int i = 0; i < 21; i++) begin
      apply((i == 0) ? S_CLR : S_ROB);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL saturation step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
    vecs++;
    if (stall_cnt !== 4'd15) begin
      errs++; $display("FAIL saturation stall_cnt: got %0d expected 15", stall_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      apply((i == 0) ? (S_ROB | S_CLR) : S_IQ);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL clear_with_bp step %0d: got %h expected %h", i, got, e);
      end
      if (i == 1 && got.scnt !== 4'd0) begin
        errs++; $display("FAIL clear_with_bp stall_cnt: got %0d expected 0", got.scnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] stim[$];
    obs_t got, e;
    stim = '{S_FR, S_RST | S_ROB, 8'h00, S_IC, S_RST | S_HI, 8'h00};
    foreach (stim[i]) begin
      apply(stim[i]);
      @(negedge clk);
      got = sample(); e = exp_q.pop_front(); vecs++;
      if (got !== e) begin
        errs++; $display("FAIL reset_mid step %0d: got %h expected %h", i, got, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    {rst, full_prf, full_rob, full_iq, flush_req, idle_commit, has_int, cnt_clr} = S_RST;
    m_st = 0; m_rc = 0; m_sc = 0; m_fc = 0;
    @(posedge clk); #1;
    test_reset();
    test_backpressure();
    test_flush_recover();
    test_back_to_back();
    test_idle();
    test_ignored();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/front_end_ctrl.md
# front_end_ctrl

Pipeline sequencer for the front end. It produces the fetch, ID→rename and sRAT flush/stall controls from backend back-pressure, ROB redirect requests, idle commit and interrupts. It runs a RUN / RECOVER / IDLE state machine so no instruction is renamed while the sRAT is being restored from the aRAT. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- RECOVER_CYCLES, default 2: cycles spent in RECOVER after a flush (sRAT restore window); legal range 1..15.
- CNT_W, default 32: width of the event counters.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- full_prf  in  1  free list empty, from the sRAT.
- full_rob  in  1  ROB cannot accept three entries.
- full_iq  in  1  OR of all issue-queue full flags.
- flush_req  in  1  ROB redirect: mispredict, exception or ertn commit.
- idle_commit  in  1  ROB committed an idle instruction.
- has_int  in  1  pending, enabled interrupt.
- cnt_clr  in  1  clear both counters.
- flush_if  out  1  kill fetch stage contents.
- stall_if  out  1  hold the fetch PC and fetch buffer.
- flush_id  out  1  clear the ID→rename register.
- stall_id  out  1  hold the ID→rename register.
- flush_srat  out  1  copy aRAT map and free list into the sRAT.
- stall_srat  out  1  hold the sRAT and inhibit allocation.
- state  out  2  RUN=0, RECOVER=1, IDLE=2.
- stall_cnt  out  CNT_W  cycles stalled by the backend.
- flush_cnt  out  CNT_W  accepted flush_req events.

## Operation
- bp = full_prf | full_rob | full_iq.
- Outputs are combinational from the current state and inputs. State and counters are registered.
- Priority, highest first: rst, flush_req, has_int (IDLE only), idle_commit (RUN only), bp.
- While rst=1:
  - flush_if = flush_id = flush_srat = 1; all stalls = 0.
  - On the clock edge: state ← RUN, counters ← 0, recover counter ← 0.
- flush_req=1, any state:
  - flush_if = flush_id = flush_srat = 1; all stalls = 0.
  - Next state RECOVER; recover counter ← RECOVER_CYCLES-1.
- RUN:
  - stall_srat = bp; stall_id = bp; stall_if = bp.
  - All flushes 0.
  - If idle_commit (and no flush_req): next state IDLE.
- RECOVER:
  - stall_if = stall_id = stall_srat = 1; all flushes 0.
  - The recover counter decrements each cycle. When it is 0 and there is no flush_req, next state is RUN.
  - A flush_req during RECOVER reloads the counter; the window restarts.
- IDLE:
  - stall_if = 1; flush_id = 1, so rename sees only bubbles; stall_srat = 0; other flushes 0.
  - has_int=1: next state RUN. The interrupt is then tagged onto the first instruction reaching ID.
  - flush_req wins over has_int.
- stall_cnt: +1 on each cycle with state==RUN, bp=1 and flush_req=0. Saturates at 2^CNT_W-1.
- flush_cnt: +1 on each cycle with flush_req=1, RECOVER included. Saturates.
- cnt_clr: sets both counters to 0 on the next edge and overrides any increment in that same cycle. It does not affect the state.
- idle_commit outside RUN is ignored.
- has_int outside IDLE is ignored; the decoder handles it.

## Timing
- Flush outputs rise in the same cycle as flush_req (zero latency).
- sRAT restore occurs at the edge that ends the flush_req cycle.
- Rename is blocked for exactly RECOVER_CYCLES cycles after the flush cycle. The first new rename is possible at cycle t+1+RECOVER_CYCLES.
- Stall outputs follow bp in the same cycle while in RUN; there is no registered delay.
- IDLE is entered on the edge after idle_commit. RUN is re-entered on the edge after has_int.
- state and the counters change only on rising clk.
- Back-to-back flush_req for N cycles keeps flush_* high for N cycles, then RECOVER_CYCLES cycles of RECOVER.

## Test plan
- Reset: hold rst for 3 cycles → flush_if/id/srat = 1, stalls = 0, state = 0, stall_cnt = flush_cnt = 0; after release, all outputs are 0.
- Back-pressure: in RUN, pulse full_rob for 4 cycles → stall_if/id/srat = 1 for exactly those 4 cycles, stall_cnt = 4, state stays 0.
- Flush/recover (RECOVER_CYCLES=2): flush_req at cycle 10 → flush_* = 1 at 10; state = 1 with all stalls = 1 at 11–12; state = 0 at 13; flush_cnt = 1.
- Flush during recovery: flush_req at 10 and again at 11 → RECOVER occupies 12–13, RUN at 14; flush_cnt = 2.
- Idle: idle_commit at 20 → state = 2 from 21 with stall_if = 1 and flush_id = 1; has_int at 30 → state = 0 at 31. Separately, flush_req together with has_int in IDLE → state = 1.
- Counter corner: CNT_W=4 with bp held 20 cycles → stall_cnt saturates at 15. cnt_clr asserted together with bp → counter reads 0 on the next cycle.
